cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
//  Byte-loaded RV32I-subset CPU with a 5-stage pipeline (IF/ID/EX/MEM/WB) and a debug read port.
//  The program is streamed in one byte per clock on instr_i, then executed.
//  Register file or data-memory bytes are read back through value_o for checking.
// PARAMETERS
//  IMEM_WORDS  64  instruction memory depth (32-bit words)
//  DMEM_WORDS  32  data memory depth (32-bit words)
// PORTS
//  clk_i        in   1  clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  instr_i      in   8  program byte stream, sampled every rising edge
//  DataOrReg    in   1  readout source: 1 = register file, 0 = data memory
//  address      in   5  readout index: register number, or data-memory word index
//  vout_addr    in   2  readout byte select; 3 = bits[31:24], 0 = bits[7:0]
//  value_o      out  8  selected byte, combinational
//  is_positive  out  1  1 when the selected 32-bit word is signed > 0
//  easter_egg   out  3  one-hot state: 001 IDLE, 010 LOAD, 100 RUN
// BEHAVIOUR
//  Reset (reset=0)
//   - Takes effect asynchronously and forces state IDLE.
//   - Clears PC, all pipeline registers, the register file, IMEM and DMEM.
//   - Outputs after reset: value_o=0, is_positive=0, easter_egg=001.
//   - Reset asserted mid-load or mid-run aborts the operation completely.
//  IDLE: instr_i==8'hFE moves the state to LOAD; every other byte is ignored.
//  LOAD
//   - Each rising edge captures one byte; four bytes form one word, little-endian (first byte = bits[7:0]).
//   - Words are stored at IMEM[0], IMEM[1], ... in order.
//   - The completed word 32'hFFFF_FFFF ends the load: it is not stored, and the next cycle is RUN.
//   - Loading a 65th word drops the extra word and forces RUN.
//  RUN: the pipeline starts fetching at PC=0 and runs until the next reset.
//  Instructions
//   - R-type: add sub and or xor slt sll srl.
//   - I-type: addi andi ori xori slti lw.
//   - S-type: sw.  B-type: beq bne.  J-type: jal.
//   - Any other encoding, including 0, executes as a NOP.
//  Data memory
//   - Word addressed by effective address bits[6:2]; higher address bits are ignored.
//   - Address bits[1:0] are ignored.
//  Register file
//   - x0 reads 0 and ignores writes.
//   - Write-first: a WB write is visible to an ID read in the same cycle.
//  Branch and jump
//   - beq, bne and jal resolve in EX.
//   - When taken: PC <= target, and the two younger instructions (in IF and ID) are flushed to bubbles.
//  Load-use: one stall cycle, then the loaded value is forwarded to EX.
//  End of program
//   - PC is a 7-bit word index. Fetch at index >= 64 returns a NOP and PC holds at 64.
//   - Branch targets outside IMEM behave the same way.
//  Readout
//   - value_o = byte vout_addr of the selected word, combinational from DataOrReg, address and vout_addr.
//   - Valid in any state.
//   - With DataOrReg=0, address values >= DMEM_WORDS wrap modulo DMEM_WORDS.
// CONFIGURATION
//  FORWARDING_EN
//   - Defined: EX/MEM->EX and MEM/WB->EX operand forwarding; only load-use stalls.
//   - Undefined: no forwarding; ID stalls on any RAW hazard with EX, MEM or WB until the producer writes back.
//   - The final architectural state is identical either way; only the cycle count differs.
// STRUCTURE
//  Package cpu_pkg
//   - Opcode and funct constants.
//   - ALU-op enum; the state enum (IDLE/LOAD/RUN).
//   - Pipeline-register struct typedefs.
//  Sub-module cpu_alu
//   - Combinational: a, b, op -> result, zero.
//   - Shifts use b[4:0]; slt is a signed compare.
// TESTING
//  1. Hold reset low, then release -> easter_egg=001; value_o=0 for every address/vout_addr.
//  2. Send FE, then "addi x8,x0,5" as bytes 13 04 50 00, then FF FF FF FF
//     -> easter_egg goes 010 then 100.
//     After 20 cycles: DataOrReg=1, address=8, vout_addr=0..3 reads 05,00,00,00; is_positive=1.
//  3. Run back-to-back dependent "addi x9,x0,-1" then "add x10,x9,x9"
//     -> x10=FFFFFFFE, read MSB first as FF,FF,FF,FE; is_positive=0.
//     Repeat without FORWARDING_EN -> same values.
//  4. Run "sw x8,4(x0)" then "lw x11,4(x0)" then "add x12,x11,x11"
//     -> DMEM word 1 = 5 (DataOrReg=0, address=1); x12 = 0000000A.
//  5. Run "beq x0,x0,+12" followed by two "addi x13,x0,1" -> x13 stays 0 (flushed or skipped).
//  6. Assert reset mid-LOAD -> IDLE; the next FE-framed program loads from IMEM[0].

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the byte-loaded RV32I-subset cpu: opcodes, funct fields,
// ALU operations, top-level state and pipeline-register layouts.
package cpu_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  // One-hot so the state drives easter_egg directly.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_LOAD = 3'b010,
    ST_RUN  = 3'b100
  } state_e;

  typedef struct packed {
    logic [6:0]  pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [6:0]  pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_beq;
    logic        is_bne;
    logic        is_jal;
  } id_ex_t;

  typedef struct packed {
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] result;
  } mem_wb_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the cpu pipeline; shifts use b[4:0], slt compares signed.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/cpu.sv
// Byte-loaded RV32I-subset cpu, 5-stage pipeline with debug readout.
// Define FORWARDING_EN for EX-stage operand forwarding; otherwise ID stalls on RAW hazards.
module cpu
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 32
)(
  input  logic       clk_i,
  input  logic       reset,
  input  logic [7:0] instr_i,
  input  logic       DataOrReg,
  input  logic [4:0] address,
  input  logic [1:0] vout_addr,
  output logic [7:0] value_o,
  output logic       is_positive,
  output logic [2:0] easter_egg
);

  localparam int unsigned IAW    = $clog2(IMEM_WORDS);
  localparam int unsigned DAW    = $clog2(DMEM_WORDS);
  localparam logic [6:0]  PC_END = 7'(IMEM_WORDS);
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  state_e      state, state_nx;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];

  // ---------------- program loader ----------------
  logic [1:0]  byte_cnt;
  logic [23:0] byte_buf;
  logic [6:0]  load_idx;
  logic [31:0] load_word;
  logic        load_done, load_store;

  assign load_word = {instr_i, byte_buf};

  always_comb begin
    load_done  = 1'b0;
    load_store = 1'b0;
    if (state == ST_LOAD && byte_cnt == 2'd3) begin
      if (load_word == '1 || load_idx == PC_END) load_done  = 1'b1;
      else                                       load_store = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (instr_i == 8'hFE) state_nx = ST_LOAD;
      ST_LOAD: if (load_done) state_nx = ST_RUN;
      default: state_nx = state;
    endcase
  end

  assign easter_egg = state;

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      byte_buf <= '0;
      load_idx <= '0;
    end else if (state == ST_LOAD) begin
      byte_cnt <= byte_cnt + 2'd1;
      byte_buf <= {instr_i, byte_buf[23:8]};
      if (load_store) load_idx <= load_idx + 7'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset)          imem <= '{default: '0};
    else if (load_store) imem[load_idx[IAW-1:0]] <= load_word;
  end

  // ---------------- pipeline ----------------
  logic        run;
  logic [6:0]  pc;
  if_id_t      if_id;
  id_ex_t      id_ex, id_ex_nx;
  ex_mem_t     ex_mem, ex_mem_nx;
  mem_wb_t     mem_wb, mem_wb_nx;
  logic [31:0] fetch_instr;

  assign run         = (state == ST_RUN);
  assign fetch_instr = (pc < PC_END) ? imem[pc[IAW-1:0]] : '0;

  // ID: decode and write-first register read
  logic [31:0] ins, rs1_val, rs2_val;
  logic [6:0]  id_opc, id_f7;
  logic [2:0]  id_f3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic        uses_rs1, uses_rs2, legal, stall;

  assign ins    = if_id.instr;
  assign id_opc = ins[6:0];
  assign id_rd  = ins[11:7];
  assign id_f3  = ins[14:12];
  assign id_rs1 = ins[19:15];
  assign id_rs2 = ins[24:20];
  assign id_f7  = ins[31:25];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  assign rs1_val = (mem_wb.reg_we && mem_wb.rd != '0 && mem_wb.rd == id_rs1) ? mem_wb.result : regs[id_rs1];
  assign rs2_val = (mem_wb.reg_we && mem_wb.rd != '0 && mem_wb.rd == id_rs2) ? mem_wb.result : regs[id_rs2];

  always_comb begin
    id_ex_nx         = '0;
    uses_rs1         = 1'b0;
    uses_rs2         = 1'b0;
    legal            = 1'b1;
    id_ex_nx.pc      = if_id.pc;
    id_ex_nx.rs1     = id_rs1;
    id_ex_nx.rs2     = id_rs2;
    id_ex_nx.rd      = id_rd;
    id_ex_nx.rs1_val = rs1_val;
    id_ex_nx.rs2_val = rs2_val;
    id_ex_nx.alu_op  = ALU_ADD;
    case (id_opc)
      OPC_R: begin
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        id_ex_nx.reg_we = 1'b1;
        case ({id_f7, id_f3})
          {F7_BASE, F3_ADD}: id_ex_nx.alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD}: id_ex_nx.alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}: id_ex_nx.alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}: id_ex_nx.alu_op = ALU_SLT;
          {F7_BASE, F3_XOR}: id_ex_nx.alu_op = ALU_XOR;
          {F7_BASE, F3_SR }: id_ex_nx.alu_op = ALU_SRL;
          {F7_BASE, F3_OR }: id_ex_nx.alu_op = ALU_OR;
          {F7_BASE, F3_AND}: id_ex_nx.alu_op = ALU_AND;
          default:           legal = 1'b0;
        endcase
      end
      OPC_I: begin
        uses_rs1         = 1'b1;
        id_ex_nx.reg_we  = 1'b1;
        id_ex_nx.use_imm = 1'b1;
        id_ex_nx.imm     = imm_i;
        case (id_f3)
          F3_ADD:  id_ex_nx.alu_op = ALU_ADD;
          F3_SLT:  id_ex_nx.alu_op = ALU_SLT;
          F3_XOR:  id_ex_nx.alu_op = ALU_XOR;
          F3_OR:   id_ex_nx.alu_op = ALU_OR;
          F3_AND:  id_ex_nx.alu_op = ALU_AND;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal            = (id_f3 == F3_W);
        uses_rs1         = 1'b1;
        id_ex_nx.reg_we  = 1'b1;
        id_ex_nx.mem_rd  = 1'b1;
        id_ex_nx.use_imm = 1'b1;
        id_ex_nx.imm     = imm_i;
      end
      OPC_STORE: begin
        legal            = (id_f3 == F3_W);
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        id_ex_nx.mem_wr  = 1'b1;
        id_ex_nx.use_imm = 1'b1;
        id_ex_nx.imm     = imm_s;
      end
      OPC_BRANCH: begin
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        id_ex_nx.alu_op = ALU_SUB;
        id_ex_nx.imm    = imm_b;
        id_ex_nx.is_beq = (id_f3 == F3_BEQ);
        id_ex_nx.is_bne = (id_f3 == F3_BNE);
        legal           = id_ex_nx.is_beq || id_ex_nx.is_bne;
      end
      OPC_JAL: begin
        id_ex_nx.reg_we = 1'b1;
        id_ex_nx.is_jal = 1'b1;
        id_ex_nx.imm    = imm_j;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      id_ex_nx = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  function automatic logic dep(input logic we, input logic [4:0] rd,
                               input logic u1, input logic u2,
                               input logic [4:0] r1, input logic [4:0] r2);
    return we && rd != '0 && ((u1 && rd == r1) || (u2 && rd == r2));
  endfunction

  // WB-stage producers never stall: the write-first register read covers them.
  assign stall = FWD ? dep(id_ex.reg_we && id_ex.mem_rd, id_ex.rd, uses_rs1, uses_rs2, id_rs1, id_rs2)
                     : (dep(id_ex.reg_we,  id_ex.rd,  uses_rs1, uses_rs2, id_rs1, id_rs2) ||
                        dep(ex_mem.reg_we, ex_mem.rd, uses_rs1, uses_rs2, id_rs1, id_rs2));

  // EX: operand select, ALU, branch resolution
  logic [31:0] op_a, op_b, alu_b, alu_res, pc_byte, tgt_word;
  logic [6:0]  tgt_pc;
  logic        alu_zero, take;

  always_comb begin
    op_a = id_ex.rs1_val;
    op_b = id_ex.rs2_val;
    if (FWD && ex_mem.reg_we && !ex_mem.mem_rd && ex_mem.rd != '0 && ex_mem.rd == id_ex.rs1)
      op_a = ex_mem.result;
    else if (FWD && mem_wb.reg_we && mem_wb.rd != '0 && mem_wb.rd == id_ex.rs1)
      op_a = mem_wb.result;
    if (FWD && ex_mem.reg_we && !ex_mem.mem_rd && ex_mem.rd != '0 && ex_mem.rd == id_ex.rs2)
      op_b = ex_mem.result;
    else if (FWD && mem_wb.reg_we && mem_wb.rd != '0 && mem_wb.rd == id_ex.rs2)
      op_b = mem_wb.result;
  end

  assign alu_b = id_ex.use_imm ? id_ex.imm : op_b;

  cpu_alu u_alu (
    .a      (op_a),
    .b      (alu_b),
    .op     (id_ex.alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign take     = id_ex.is_jal || (id_ex.is_beq && alu_zero) || (id_ex.is_bne && !alu_zero);
  assign pc_byte  = {23'd0, id_ex.pc, 2'b00};
  // Target computed as a word index; negative or past-the-end targets park at PC_END.
  assign tgt_word = {25'd0, id_ex.pc} + {{2{id_ex.imm[31]}}, id_ex.imm[31:2]};
  assign tgt_pc   = (tgt_word < IMEM_WORDS) ? tgt_word[6:0] : PC_END;

  always_comb begin
    ex_mem_nx            = '0;
    ex_mem_nx.reg_we     = id_ex.reg_we;
    ex_mem_nx.mem_rd     = id_ex.mem_rd;
    ex_mem_nx.mem_wr     = id_ex.mem_wr;
    ex_mem_nx.rd         = id_ex.rd;
    ex_mem_nx.result     = id_ex.is_jal ? pc_byte + 32'd4 : alu_res;
    ex_mem_nx.store_data = op_b;
  end

  // MEM
  logic [DAW-1:0] dmem_idx;
  assign dmem_idx = ex_mem.result[2 +: DAW];

  always_comb begin
    mem_wb_nx        = '0;
    mem_wb_nx.reg_we = ex_mem.reg_we;
    mem_wb_nx.rd     = ex_mem.rd;
    mem_wb_nx.result = ex_mem.mem_rd ? dmem[dmem_idx] : ex_mem.result;
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (run) begin
      ex_mem <= ex_mem_nx;
      mem_wb <= mem_wb_nx;
      if (take) begin
        pc    <= tgt_pc;
        if_id <= '0;
        id_ex <= '0;
      end else if (stall) begin
        id_ex <= '0;
      end else begin
        pc          <= (pc < PC_END) ? pc + 7'd1 : pc;
        if_id.pc    <= pc;
        if_id.instr <= fetch_instr;
        id_ex       <= id_ex_nx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset)                                        regs <= '{default: '0};
    else if (run && mem_wb.reg_we && mem_wb.rd != '0) regs[mem_wb.rd] <= mem_wb.result;
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset)                    dmem <= '{default: '0};
    else if (run && ex_mem.mem_wr) dmem[dmem_idx] <= ex_mem.store_data;
  end

  // ---------------- readout ----------------
  logic [31:0] rd_word;
  assign rd_word     = DataOrReg ? regs[address] : dmem[address[DAW-1:0]];
  assign is_positive = !rd_word[31] && (rd_word != '0);

  always_comb begin
    case (vout_addr)
      2'd0:    value_o = rd_word[7:0];
      2'd1:    value_o = rd_word[15:8];
      2'd2:    value_o = rd_word[23:16];
      default: value_o = rd_word[31:24];
    endcase
  end

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: loads hand-encoded programs and reads back state.
module tb_cpu;

  logic       clk_i     = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] instr_i   = '0;
  logic       DataOrReg = 1'b0;
  logic [4:0] address   = '0;
  logic [1:0] vout_addr = '0;
  logic [7:0] value_o;
  logic       is_positive;
  logic [2:0] easter_egg;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog[$];

  cpu #(.IMEM_WORDS(64), .DMEM_WORDS(32)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .instr_i     (instr_i),
    .DataOrReg   (DataOrReg),
    .address     (address),
    .vout_addr   (vout_addr),
    .value_o     (value_o),
    .is_positive (is_positive),
    .easter_egg  (easter_egg)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    instr_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    instr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_prog(input bit term);
    send(8'hFE);
    check("state_load", {29'd0, easter_egg}, 32'd2);
    foreach (prog[i]) send_word(prog[i]);
    if (term) send_word(32'hFFFF_FFFF);
    check("state_run", {29'd0, easter_egg}, 32'd4);
    instr_i = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_word(input string tag, input logic src, input logic [4:0] idx,
                            input logic [31:0] exp);
    logic [31:0] w;
    DataOrReg = src;
    address   = idx;
    for (int i = 3; i >= 0; i--) begin
      vout_addr = 2'(i);
      #1;
      w[8*i +: 8] = value_o;
    end
    check(tag, w, exp);
  endtask

  initial begin
    // 1: reset state
    do_reset();
    check("reset_state", {29'd0, easter_egg}, 32'd1);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 4; b++) begin
          DataOrReg = s[0];
          address   = 5'(a);
          vout_addr = 2'(b);
          #1;
          check("reset_value", {24'd0, value_o}, 32'd0);
        end
      end
    end
    check("reset_pos", {31'd0, is_positive}, 32'd0);

    // 2: addi x8,x0,5
    do_reset();
    send(8'h00);
    check("idle_ignores", {29'd0, easter_egg}, 32'd1);
    prog = {32'h0050_0413};
    load_prog(1'b1);
    wait_cycles(20);
    check_word("x8", 1'b1, 5'd8, 32'h0000_0005);
    check("x8_pos", {31'd0, is_positive}, 32'd1);

    // 3: dependent addi/add
    do_reset();
    prog = {32'hFFF0_0493, 32'h0094_8533};
    load_prog(1'b1);
    wait_cycles(20);
    check_word("x9", 1'b1, 5'd9, 32'hFFFF_FFFF);
    check_word("x10", 1'b1, 5'd10, 32'hFFFF_FFFE);
    check("x10_pos", {31'd0, is_positive}, 32'd0);

    // 4: store, load, load-use, high address bits ignored
    do_reset();
    prog = {32'h0050_0413, 32'h0080_2223, 32'h0040_2583, 32'h00B5_8633, 32'h0840_2C83};
    load_prog(1'b1);
    wait_cycles(30);
    check_word("dmem1", 1'b0, 5'd1, 32'h0000_0005);
    check_word("dmem0", 1'b0, 5'd0, 32'h0000_0000);
    check_word("x11", 1'b1, 5'd11, 32'h0000_0005);
    check_word("x12", 1'b1, 5'd12, 32'h0000_000A);
    check_word("x25_wrap", 1'b1, 5'd25, 32'h0000_0005);

    // 5: taken beq flushes the two younger instructions
    do_reset();
    prog = {32'h0000_0663, 32'h0010_0693, 32'h0010_0693, 32'h0070_0713};
    load_prog(1'b1);
    wait_cycles(20);
    check_word("x13_flushed", 1'b1, 5'd13, 32'h0000_0000);
    check_word("x14_target", 1'b1, 5'd14, 32'h0000_0007);

    // ALU ops, jal, bne, x0 write
    do_reset();
    prog = {32'h00C0_0093, 32'h00A0_0113, 32'h4020_81B3, 32'h0020_F233,
            32'h0020_E2B3, 32'h0020_C333, 32'h0011_23B3, 32'h0020_97B3,
            32'h0030_D833, 32'h0080_096F, 32'h0010_0993, 32'h0020_9463,
            32'h0010_0A13, 32'h0090_0A93, 32'h0050_0013};
    load_prog(1'b1);
    wait_cycles(60);
    check_word("sub", 1'b1, 5'd3, 32'd2);
    check_word("and", 1'b1, 5'd4, 32'd8);
    check_word("or", 1'b1, 5'd5, 32'd14);
    check_word("xor", 1'b1, 5'd6, 32'd6);
    check_word("slt", 1'b1, 5'd7, 32'd1);
    check_word("sll", 1'b1, 5'd15, 32'h0000_3000);
    check_word("srl", 1'b1, 5'd16, 32'd3);
    check_word("jal_link", 1'b1, 5'd18, 32'h0000_0028);
    check_word("jal_skip", 1'b1, 5'd19, 32'd0);
    check_word("bne_skip", 1'b1, 5'd20, 32'd0);
    check_word("bne_target", 1'b1, 5'd21, 32'd9);
    check_word("x0_zero", 1'b1, 5'd0, 32'd0);

    // 64-word IMEM fill; the 65th word is dropped and forces RUN
    do_reset();
    prog = {};
    for (int i = 0; i < 65; i++) prog.push_back(i < 64 ? 32'h001B_0B13 : 32'h0010_0B93);
    load_prog(1'b0);
    wait_cycles(300);
    check_word("imem_full_chain", 1'b1, 5'd22, 32'd64);
    check_word("word65_dropped", 1'b1, 5'd23, 32'd0);

    // 6: reset mid-load aborts, next load starts at IMEM[0]
    do_reset();
    send(8'hFE);
    send_word(32'h0030_0C13);
    send(8'h13);
    send(8'h04);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_idle", {29'd0, easter_egg}, 32'd1);
    do_reset();
    prog = {32'h0050_0413};
    load_prog(1'b1);
    wait_cycles(20);
    check_word("reload_x8", 1'b1, 5'd8, 32'h0000_0005);
    check_word("reload_x24", 1'b1, 5'd24, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
